karatsuba_dot_accumulator: RTL and testbench

- Downstream consumer of the 8x8 combinational `karatsuba` multiplier.
- Accepts a stream of 16-bit products `Z` over a valid/ready handshake.
- Sums a programmed number of products into a dot-product result, then holds that result on an output valid/ready handshake.
- Upstream it sits behind the multiplier; downstream it feeds any result sink, for example a register file or a bench monitor.

---
 rtl/karatsuba_pkg.sv | 8 +
 rtl/karatsuba_acc_add.sv | 20 ++
 rtl/karatsuba_dot_accumulator.sv | 78 +++++++
 tb/tb_karatsuba_dot_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared widths and FSM states for the karatsuba multiplier and its dot-product accumulator
package karatsuba_pkg;
    localparam int KARATSUBA_OP_W = 8;
    localparam int PROD_W_DEF     = 2 * KARATSUBA_OP_W;
    localparam int ACC_W_DEF      = 24;
    localparam int LEN_W_DEF      = 4;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
endpackage

// File: rtl/karatsuba_acc_add.sv
// karatsuba_acc_add: one-product accumulate step with carry-out; wraps by default, saturates when KARATSUBA_ACC_SAT_EN is defined
module karatsuba_acc_add #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] val_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);
    logic [ACC_W:0] sum_w;
    assign sum_w   = {1'b0, acc_i} + (ACC_W + 1)'(val_i);
    assign carry_o = sum_w[ACC_W];
`ifdef KARATSUBA_ACC_SAT_EN
    // once all-ones, any nonzero product carries again, so the value stays pinned
    assign sum_o = carry_o ? '1 : sum_w[ACC_W-1:0];
`else
    assign sum_o = sum_w[ACC_W-1:0];
`endif
endmodule

// File: rtl/karatsuba_dot_accumulator.sv
// karatsuba_dot_accumulator: sums len products from the multiplier and holds the result on a valid/ready output (KARATSUBA_ACC_SAT_EN selects saturation)
module karatsuba_dot_accumulator
    import karatsuba_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              p_valid_i,
    input  logic [PROD_W-1:0] p_data_i,
    output logic              p_ready_o,
    output logic              acc_valid_o,
    output logic [ACC_W-1:0]  acc_data_o,
    input  logic              acc_ready_i,
    output logic              busy_o,
    output logic              overflow_o
);
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, sum_w;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d, carry_w;

    karatsuba_acc_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc_i   (acc_q),
        .val_i   (p_data_i),
        .sum_o   (sum_w),
        .carry_o (carry_w)
    );

    // next state: start loads the vector, each accepted beat adds and counts down, the sink drains the result
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start_i) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = len_i;
                state_d = (len_i != '0) ? ACCUM : DONE;
            end
            ACCUM: if (p_valid_i) begin
                acc_d   = sum_w;
                ovf_d   = ovf_q | carry_w;
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? DONE : ACCUM;
            end
            DONE: state_d = acc_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset discards any partial sum
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign p_ready_o   = (state_q == ACCUM);
    assign acc_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign acc_data_o  = acc_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_karatsuba_dot_accumulator.sv
// tb_karatsuba_dot_accumulator: table, random and corner-case checks of 24-bit and 16-bit accumulators fed identical stimulus
module tb_karatsuba_dot_accumulator;
    logic        clk = 1'b0, rst_ni = 1'b1, start_i = 1'b0, p_valid_i = 1'b0, acc_ready_i = 1'b0;
    logic [3:0]  len_i = '0;
    logic [15:0] p_data_i = '0;
    logic        p_ready, acc_valid, busy, overflow;
    logic [23:0] acc_data;
    logic        p_ready16, acc_valid16, busy16, overflow16;
    logic [15:0] acc_data16;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    karatsuba_dot_accumulator dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .p_valid_i(p_valid_i), .p_data_i(p_data_i), .p_ready_o(p_ready),
        .acc_valid_o(acc_valid), .acc_data_o(acc_data), .acc_ready_i(acc_ready_i),
        .busy_o(busy), .overflow_o(overflow)
    );

    karatsuba_dot_accumulator #(.ACC_W(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .p_valid_i(p_valid_i), .p_data_i(p_data_i), .p_ready_o(p_ready16),
        .acc_valid_o(acc_valid16), .acc_data_o(acc_data16), .acc_ready_i(acc_ready_i),
        .busy_o(busy16), .overflow_o(overflow16)
    );

    typedef struct {
        string       nm;
        int          len;
        int          gap;
        logic [15:0] b[3];
        logic [23:0] e24;
        logic        o24;
        logic [15:0] e16;
        logic        o16;
        int          hold;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // expected result from the true (unbounded) sum of the beats
    function automatic void model(input logic [15:0] bs[$], input int w, output logic [23:0] res, output logic ovf);
        longint tot = 0;
        longint lim = longint'(1) << w;
        foreach (bs[i]) tot += longint'(bs[i]);
        ovf = (tot >= lim);
`ifdef KARATSUBA_ACC_SAT_EN
        res = ovf ? 24'(lim - 1) : 24'(tot);
`else
        res = 24'(tot % lim);
`endif
    endfunction

    task automatic run_vec(input string nm, input int len, input int gap, input logic [15:0] bs[$],
                           input logic [23:0] e24, input logic o24, input logic [15:0] e16,
                           input logic o16, input int hold);
        start_i = 1'b1;
        len_i   = 4'(len);
        step;
        start_i = 1'b0;
        chk({nm, "_busy"}, 64'(busy), 1);
        chk({nm, "_p_ready"}, 64'(p_ready), (len != 0) ? 1 : 0);
        for (int i = 0; i < len; i++) begin
            repeat (gap) begin
                p_valid_i = 1'b0;
                start_i   = 1'($urandom);
                len_i     = 4'($urandom);
                step;
            end
            start_i   = 1'b0;
            p_valid_i = 1'b1;
            p_data_i  = bs[i];
            if (i == len - 1) chk({nm, "_early_valid"}, 64'(acc_valid), 0);
            step;
        end
        p_valid_i = 1'b0;
        chk({nm, "_acc_valid"}, 64'(acc_valid), 1);
        chk({nm, "_acc_valid16"}, 64'(acc_valid16), 1);
        chk({nm, "_acc_data"}, 64'(acc_data), 64'(e24));
        chk({nm, "_acc_data16"}, 64'(acc_data16), 64'(e16));
        chk({nm, "_overflow"}, 64'(overflow), 64'(o24));
        chk({nm, "_overflow16"}, 64'(overflow16), 64'(o16));
        repeat (hold) begin
            p_valid_i = 1'b1;
            p_data_i  = 16'($urandom);
            start_i   = 1'b1;
            len_i     = 4'd3;
            step;
            chk({nm, "_hold_valid"}, 64'(acc_valid), 1);
            chk({nm, "_hold_data"}, 64'(acc_data), 64'(e24));
            chk({nm, "_hold_p_ready"}, 64'(p_ready), 0);
        end
        p_valid_i   = 1'b0;
        start_i     = 1'b1;
        len_i       = 4'd5;
        acc_ready_i = 1'b1;
        step;
        start_i     = 1'b0;
        acc_ready_i = 1'b0;
        chk({nm, "_drain_valid"}, 64'(acc_valid), 0);
        chk({nm, "_drain_busy"}, 64'(busy), 0);
        chk({nm, "_idle_data"}, 64'(acc_data), 64'(e24));
        chk({nm, "_idle_data16"}, 64'(acc_data16), 64'(e16));
    endtask

    initial begin
        logic [15:0] q[$];
        logic [23:0] r24, r16;
        logic        v24, v16;

        tbl[0] = '{"basic",  3, 0, '{16'd525, 16'd525, 16'd525}, 24'd1575, 1'b0, 16'd1575, 1'b0, 0};
        tbl[1] = '{"gaps",   2, 2, '{16'd100, 16'd200, 16'd0},   24'd300,  1'b0, 16'd300,  1'b0, 5};
        tbl[2] = '{"len0",   0, 0, '{16'd0, 16'd0, 16'd0},       24'd0,    1'b0, 16'd0,    1'b0, 1};
`ifdef KARATSUBA_ACC_SAT_EN
        tbl[3] = '{"ovf",    2, 0, '{16'd65535, 16'd2, 16'd0},   24'd65537, 1'b0, 16'd65535, 1'b1, 0};
        tbl[5] = '{"ovf3",   3, 1, '{16'hFFFF, 16'hFFFF, 16'hFFFF}, 24'd196605, 1'b0, 16'd65535, 1'b1, 2};
`else
        tbl[3] = '{"ovf",    2, 0, '{16'd65535, 16'd2, 16'd0},   24'd65537, 1'b0, 16'd1, 1'b1, 0};
        tbl[5] = '{"ovf3",   3, 1, '{16'hFFFF, 16'hFFFF, 16'hFFFF}, 24'd196605, 1'b0, 16'd65533, 1'b1, 2};
`endif
        tbl[4] = '{"single", 1, 1, '{16'd7, 16'd0, 16'd0},       24'd7,    1'b0, 16'd7,    1'b0, 0};

        #1 rst_ni = 1'b0;
        #1;
        chk("rst_async_p_ready", 64'(p_ready), 0);
        chk("rst_async_busy", 64'(busy), 0);
        repeat (4) begin
            start_i     = 1'($urandom);
            len_i       = 4'($urandom);
            p_valid_i   = 1'($urandom);
            p_data_i    = 16'($urandom);
            acc_ready_i = 1'($urandom);
            step;
            chk("rst_p_ready", 64'(p_ready), 0);
            chk("rst_acc_valid", 64'(acc_valid), 0);
            chk("rst_acc_data", 64'(acc_data), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_overflow", 64'(overflow), 0);
        end
        start_i = 1'b0; p_valid_i = 1'b0; acc_ready_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) begin
            step;
            chk("idle_p_ready", 64'(p_ready), 0);
            chk("idle_busy", 64'(busy), 0);
        end

        foreach (tbl[k]) begin
            q = {};
            for (int i = 0; i < tbl[k].len; i++) q.push_back(tbl[k].b[i]);
            run_vec(tbl[k].nm, tbl[k].len, tbl[k].gap, q, tbl[k].e24, tbl[k].o24,
                    tbl[k].e16, tbl[k].o16, tbl[k].hold);
        end

        start_i = 1'b1; len_i = 4'd3; step;
        start_i = 1'b0; p_valid_i = 1'b1; p_data_i = 16'd50; step;
        p_valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chk("abort_p_ready", 64'(p_ready), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_acc_data", 64'(acc_data), 0);
        chk("abort_acc_valid", 64'(acc_valid), 0);
        step;
        rst_ni = 1'b1;
        step;
        q = {16'd7};
        run_vec("post_abort", 1, 0, q, 24'd7, 1'b0, 16'd7, 1'b0, 0);

        for (int n = 0; n < 25; n++) begin
            int len;
            len = int'($urandom_range(0, 15));
            q = {};
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 1) == 1) ? 16'hFF00 | 16'($urandom_range(0, 255)) : 16'($urandom));
            model(q, 24, r24, v24);
            model(q, 16, r16, v16);
            run_vec("rand", len, int'($urandom_range(0, 2)), q, r24, v24, r16[15:0], v16,
                    int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
